// File: rtl/k2red_inv.sv
// k2red_inv: restores the normal Kyber domain after K2RED arithmetic.
// Multiplies a 12-bit coefficient by k^-2 mod q (2285) and returns the
// fully reduced product in [0, q-1] through a 3-stage valid/ready pipeline.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset (clears stage valids and r)
//   in_vld   input coefficient valid
//   in_rdy   block accepts input this cycle (= !stall, combinational)
//   a        input coefficient, any value 0..4095
//   out_vld  result valid
//   out_rdy  downstream accepts result
//   r        registered result a*KINV2 mod Q, always 0..Q-1
module k2red_inv #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned KINV2 = 2285,
  parameter int unsigned DW    = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] a,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] r
);

  // Product width: 3328 * 2285 = 7,604,480 < 2^23.
  localparam int PW = 23;
  // Barrett constant floor(2^35 / 3329) and the width of p * m.
  localparam int          BS = 35;
  localparam int          BW = PW + 24;
  localparam logic [23:0] BM = 24'd10321339;

  localparam logic [DW-1:0] Q_DW    = DW'(Q);
  localparam logic [DW:0]   Q_R     = (DW+1)'(Q);
  localparam logic [PW-1:0] KINV2_P = PW'(KINV2);

  logic          v1_q, v2_q, v3_q;
  logic [DW-1:0] a1_q, a1_d;
  logic [PW-1:0] p2_q, p2_d;
  logic [DW-1:0] r_q, r_d;

  logic          stall;
  logic [DW-1:0] q_est;
  logic [DW:0]   qq;
  logic [DW:0]   r_pre;

  assign stall   = v3_q && !out_rdy;
  assign in_rdy  = !stall;
  assign out_vld = v3_q;
  assign r       = r_q;

  always_comb begin
    a1_d  = (a >= Q_DW) ? a - Q_DW : a;
    p2_d  = PW'(a1_q) * KINV2_P;
    // Barrett estimate undershoots floor(p/Q) by at most one, so the
    // remainder lands in [0, 2Q). Both terms are taken mod 2^13, which is
    // exact because the true difference is below 2Q < 2^13.
    q_est = DW'((BW'(p2_q) * BW'(BM)) >> BS);
    qq    = (DW+1)'(q_est) * Q_R;
    r_pre = p2_q[DW:0] - qq;
    r_d   = (r_pre >= Q_R) ? DW'(r_pre - Q_R) : DW'(r_pre);
  end

  // Data registers only load behind a valid entry so r keeps its last
  // value while S3 is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      a1_q <= '0;
      p2_q <= '0;
      r_q  <= '0;
    end else if (!stall) begin
      v1_q <= in_vld;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_vld) a1_q <= a1_d;
      if (v1_q)   p2_q <= p2_d;
      if (v2_q)   r_q  <= r_d;
    end
  end

endmodule

// File: tb/tb_k2red_inv.sv
// Self-checking bench for k2red_inv: directed values, streaming,
// backpressure, random handshakes and mid-stream reset, all scored against
// a plain-arithmetic reference (a * 2285 mod 3329).
module tb_k2red_inv;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [11:0] a;
  logic        out_vld;
  logic        out_rdy;
  logic [11:0] r;

  int unsigned total;
  int unsigned bad;
  int unsigned n_out;

  int unsigned sb_q[$];
  logic        prev_stall;
  logic        prev_v;
  logic [11:0] prev_r;

  k2red_inv dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .a       (a),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .r       (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic int unsigned ref_mod(input int unsigned x);
    return (x * 2285) % 3329;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Monitor: handshakes are decided during the cycle, so sample on negedge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_rdy_rule", {31'b0, in_rdy}, {31'b0, !(out_vld && !out_rdy)});
      if (prev_stall) begin
        chk("hold_vld", {31'b0, out_vld}, {31'b0, prev_v});
        chk("hold_r", {20'b0, r}, {20'b0, prev_r});
      end
      if (out_vld) chk("r_range", {31'b0, (r < 12'd3329)}, 32'd1);
      if (out_vld && out_rdy) begin
        n_out++;
        if (sb_q.size() == 0) chk("extra_out", {20'b0, r}, 32'hFFFF_FFFF);
        else chk("scoreboard", {20'b0, r}, sb_q.pop_front());
      end
      if (in_vld && in_rdy) sb_q.push_back(ref_mod(int'(a)));
      prev_stall = out_vld && !out_rdy;
      prev_v     = out_vld;
      prev_r     = r;
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int unsigned val, input int unsigned exp_r);
    int lat;
    drive_edge();
    in_vld  = 1'b1;
    a       = 12'(val);
    out_rdy = 1'b1;
    @(negedge clk);
    chk("accept", {31'b0, in_rdy}, 32'd1);
    drive_edge();
    in_vld = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_vld && lat < 10);
    chk("latency", 32'(lat), 32'd3);
    chk("direct_r", {20'b0, r}, exp_r);
  endtask

  task automatic drain();
    int n;
    drive_edge();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || out_vld) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int first, cnt, sent, cyc, outs_before;
    int unsigned dvals[7] = '{0, 1, 169, 338, 3329, 3328, 4095};
    int unsigned dexp[7]  = '{0, 2285, 1, 2, 0, 1044, 2585};

    total = 0; bad = 0; n_out = 0;
    prev_stall = 1'b0; prev_v = 1'b0; prev_r = '0;
    rst = 1'b1; in_vld = 1'b0; a = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_vld", {31'b0, out_vld}, 32'd0);
    chk("rst_r", {20'b0, r}, 32'd0);
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      send_one(dvals[i], dexp[i]);
      drain();
    end

    // Back-to-back stream 1..200
    first = -1; cnt = 0;
    for (int c = 0; c < 210; c++) begin
      drive_edge();
      out_rdy = 1'b1;
      in_vld  = (c < 200);
      a       = 12'(c + 1);
      @(negedge clk);
      if (out_vld) begin
        if (first < 0) first = c;
        cnt++;
      end
    end
    chk("stream_count", 32'(cnt), 32'd200);
    chk("stream_first", 32'(first), 32'd3);
    drain();

    // Backpressure: 10 values, out_rdy low for 5 cycles mid-stream
    sent = 0; outs_before = int'(n_out);
    for (int c = 0; c < 30; c++) begin
      drive_edge();
      out_rdy = !(c >= 5 && c < 10);
      in_vld  = (sent < 10);
      if (c == 0 || !in_vld) a = 12'($urandom_range(0, 4095));
      @(negedge clk);
      if (c == 5) chk("bp_stall_in_rdy", {31'b0, in_rdy}, 32'd0);
      if (in_vld && in_rdy) begin
        sent++;
        drive_edge();
        a = 12'($urandom_range(0, 4095));
        out_rdy = !(c + 1 >= 5 && c + 1 < 10);
        in_vld  = (sent < 10);
        c++;
        @(negedge clk);
        if (c == 5) chk("bp_stall_in_rdy", {31'b0, in_rdy}, 32'd0);
        if (in_vld && in_rdy) sent++;
      end
    end
    drain();
    chk("bp_delivered", 32'(int'(n_out) - outs_before), 32'd10);

    // Random handshakes, 5000 values
    sent = 0; cyc = 0;
    in_vld = 1'b0;
    while (sent < 5000 && cyc < 40000) begin
      drive_edge();
      if (!(in_vld && !in_rdy)) a = 12'($urandom_range(0, 4095));
      in_vld  = $urandom_range(0, 1) != 0;
      out_rdy = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (in_vld && in_rdy) sent++;
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd5000);
    drain();

    // Reset with three values in flight
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      in_vld = 1'b1; out_rdy = 1'b1; a = 12'(100 + i);
    end
    drive_edge();
    in_vld = 1'b0; out_rdy = 1'b0; rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_vld", {31'b0, out_vld}, 32'd0);
    chk("mrst_r", {20'b0, r}, 32'd0);
    chk("mrst_in_rdy", {31'b0, in_rdy}, 32'd1);
    outs_before = int'(n_out);
    drive_edge();
    out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    chk("mrst_no_ghost", 32'(int'(n_out) - outs_before), 32'd0);
    send_one(169, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
